serial_adder: RTL and testbench

- Parametrised bit-serial adder: one full-adder cell plus a carry flip-flop computes a WIDTH-bit sum at one bit per clock, LSB first.
- Successor to the combinational half-adder cell; trades latency for area in wide datapath arithmetic.
- Operands load under a start/busy/done handshake. Result and carry-out hold stable until the next accepted start.

---
 rtl/serial_adder.sv | 119 +++++++++++
 tb/tb_serial_adder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop, LSB first.
// Optional subtract mode via `define SERIAL_ADDER_SUB_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_c;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;

  logic             w_sub;
  logic [WIDTH-1:0] w_b_ld;
  logic             w_s;
  logic             w_c;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_sum_nxt;

`ifdef SERIAL_ADDER_SUB_EN
  assign w_sub = sub;
`else
  assign w_sub = 1'b0;
`endif

  // Subtract is a + ~b + 1: invert b at load, seed carry with 1.
  assign w_b_ld   = w_sub ? ~b : b;
  assign w_s      = r_a[0] ^ r_b[0] ^ r_c;
  assign w_c      = (r_a[0] & r_b[0])
                  | (r_a[0] & r_c)
                  | (r_b[0] & r_c);
  assign w_accept = start
                  & ((r_state == S_IDLE)
                  |  (r_state == S_DONE));
  assign w_last   = (r_state == S_RUN)
                  & (r_cnt == LAST);

  generate
    if (WIDTH == 1) begin : g_w1
      assign w_sum_nxt = w_s;
    end else begin : g_wn
      assign w_sum_nxt = {w_s, r_sum[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_c     <= 1'b0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (w_accept) begin
      r_state <= S_RUN;
      r_a     <= a;
      r_b     <= w_b_ld;
      r_c     <= w_sub;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (1'b1)
        (r_state == S_RUN): begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_c   <= w_c;
          r_sum <= w_sum_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_state <= S_DONE;
            r_cout  <= w_c;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: vector table, scoreboard and corner sequences.
// Subtract checks build only with SERIAL_ADDER_SUB_EN defined.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] sum;
  logic       cout;
  logic       busy;
  logic       done;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic [0:0] sum1;
  logic       cout1;
  logic       busy1;
  logic       done1;

`ifdef SERIAL_ADDER_SUB_EN
  logic       sub;
  logic       sub1;
`endif

  int         n_vec;
  int         n_err;
  logic [8:0] q[$];
  logic [8:0] m_exp;
  logic       pat_ok;

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic [7:0] es;
    logic       ec;
  } vec_t;

  vec_t vt[6];

  serial_adder #(.WIDTH(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .a     (a),
    .b     (b),
    .sum   (sum),
    .cout  (cout),
    .busy  (busy),
    .done  (done)
  );

  serial_adder #(.WIDTH(1)) u_w1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub1),
`endif
    .a     (a1),
    .b     (b1),
    .sum   (sum1),
    .cout  (cout1),
    .busy  (busy1),
    .done  (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && done) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected_done sum=%h cout=%b",
                 sum, cout);
      end else begin
        m_exp = q.pop_front();
        if ({cout, sum} !== m_exp) begin
          n_err++;
          $display("FAIL sb_result got=%b/%h want=%b/%h",
                   cout, sum, m_exp[8], m_exp[7:0]);
        end
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic run_op(input logic [7:0] va,
                        input logic [7:0] vb,
                        input logic [7:0] es,
                        input logic       ec,
                        input int         poke);
    logic ok;
    @(negedge clk);
    start = 1'b1;
    a     = va;
    b     = vb;
    q.push_back({ec, es});
    ok = 1'b1;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (t == 0) begin
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
      end
      if (busy !== 1'b1 || done !== 1'b0) ok = 1'b0;
      if (t == poke) begin
        start = 1'b1;
        a     = 8'h11;
        b     = 8'h11;
      end else if (t == poke + 1) begin
        start = 1'b0;
      end
    end
    chk("busy_window", {31'd0, ok}, 32'd1);
    @(negedge clk);
    chk("done_timing", {30'd0, done, busy}, 32'd2);
    @(negedge clk);
    chk("hold", {22'd0, done, busy, cout, sum},
        {22'd0, 2'b00, ec, es});
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    start1 = 1'b0;
    a1     = '0;
    b1     = '0;
`ifdef SERIAL_ADDER_SUB_EN
    sub    = 1'b0;
    sub1   = 1'b0;
`endif
    vt[0] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    vt[1] = '{8'h5A, 8'h3C, 8'h96, 1'b0};
    vt[2] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vt[3] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
    vt[4] = '{8'h80, 8'h7F, 8'hFF, 1'b0};
    vt[5] = '{8'h01, 8'h02, 8'h03, 1'b0};

    #12;
    chk("reset_state", {21'd0, done, busy, cout, sum}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i])
      run_op(vt[i].va, vt[i].vb, vt[i].es, vt[i].ec, -1);

    run_op(8'h5A, 8'h3C, 8'h96, 1'b0, 3);

    @(negedge clk);
    start = 1'b1;
    a     = 8'h01;
    b     = 8'h02;
    repeat (3) q.push_back({1'b0, 8'h03});
    pat_ok = 1'b1;
    for (int t = 0; t < 28; t++) begin
      @(negedge clk);
      if (done !== ((t % 9) == 8)) pat_ok = 1'b0;
      if (t == 18) start = 1'b0;
    end
    chk("b2b_done_pattern", {31'd0, pat_ok}, 32'd1);

    @(negedge clk);
    start = 1'b1;
    a     = 8'h5A;
    b     = 8'h3C;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", {21'd0, done, busy, cout, sum}, 32'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", {30'd0, done, busy}, 32'd0);
    run_op(8'h80, 8'h80, 8'h00, 1'b1, -1);

`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b1;
    run_op(8'h10, 8'h01, 8'h0F, 1'b1, -1);
    run_op(8'h00, 8'h01, 8'hFF, 1'b0, -1);
    run_op(8'h5A, 8'h3C, 8'h1E, 1'b1, -1);
    sub = 1'b0;
    run_op(8'h10, 8'h01, 8'h11, 1'b0, -1);
`endif

    @(negedge clk);
    start1 = 1'b1;
    a1     = 1'b1;
    b1     = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    a1     = 1'b0;
    chk("w1_run", {30'd0, busy1, done1}, 32'd2);
    @(negedge clk);
    chk("w1_done", {29'd0, done1, cout1, sum1}, 32'd6);
    @(negedge clk);
    start1 = 1'b1;
    a1     = 1'b1;
    b1     = 1'b0;
    repeat (2) @(negedge clk);
    start1 = 1'b0;
    chk("w1_done2", {29'd0, done1, cout1, sum1}, 32'd5);

    repeat (3) @(negedge clk);
    chk("sb_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
